// File: rtl/busrq_arbiter_pkg.sv
// Shared types and helpers for the Z80 bus-request arbiter.
package busrq_arbiter_pkg;

    // Width of the owner index; covers up to eight requesters.
    localparam int OWNER_W = 3;

    typedef enum logic [2:0] {
        ARB_IDLE    = 3'd0,
        ARB_REQ     = 3'd1,
        ARB_GRANT   = 3'd2,
        ARB_TURN    = 3'd3,
        ARB_RELEASE = 3'd4
    } busrq_arb_state_t;

    // Requester index visited at step 'offs' of a round-robin search that
    // begins just after 'last'.
    function automatic logic [OWNER_W-1:0] rr_index(input logic [OWNER_W-1:0] last,
                                                    input int offs,
                                                    input int nreq);
        logic [31:0] sum;
        sum = 32'(last) + 32'd1 + 32'(offs);
        return OWNER_W'(sum % 32'(nreq));
    endfunction

endpackage

// File: rtl/busrq_arbiter_if.sv
// Handshake bundle between the arbiter, the requesters and the Z80 bus pins.
interface busrq_arbiter_if #(
    parameter int NREQ = 3
);
    import busrq_arbiter_pkg::*;

    logic               n_rstcpu;
    logic               n_int_next;
    logic               en;
    logic [NREQ-1:0]    req;
    logic               n_busak;
    logic               n_busrq;
    logic [NREQ-1:0]    grant;
    logic [OWNER_W-1:0] owner;
    logic               busy;
    logic               timeout;

    // Arbiter side: drives BUSRQ and the grants.
    modport master (
        input  n_rstcpu, n_int_next, en, req, n_busak,
        output n_busrq, grant, owner, busy, timeout
    );

    // System side: CPU pins and requesters.
    modport slave (
        output n_rstcpu, n_int_next, en, req, n_busak,
        input  n_busrq, grant, owner, busy, timeout
    );

endinterface

// File: rtl/busrq_arbiter_rr_pick.sv
// Combinational round-robin picker: first active request after 'last'.
module busrq_rr_pick
    import busrq_arbiter_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0]    req,
    input  logic [OWNER_W-1:0] last,
    output logic               valid,
    output logic [OWNER_W-1:0] idx
);

    localparam logic [NREQ-1:0] ONE_REQ = NREQ'(1'b1);

    logic [OWNER_W-1:0] cand_s;

    // Walk the requesters once starting at last+1 and keep the first hit.
    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        cand_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand_s = rr_index(last, i, NREQ);
            if (!valid && (|(req & (ONE_REQ << cand_s)))) begin
                valid = 1'b1;
                idx   = cand_s;
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/busrq_arbiter.sv
// Z80 BUSRQ/BUSAK arbiter: shares the CPU bus among NREQ requesters with
// round-robin fairness, burst limiting, INT yield and CPU-reset abort.
module busrq_arbiter
    import busrq_arbiter_pkg::*;
#(
    parameter int NREQ        = 3,
    parameter int MAX_BURST   = 64,   // 0 = unlimited
    parameter int ACK_TIMEOUT = 255   // must be at least 1
) (
    input  logic            clkcpu,
    input  logic            rst_n,
    busrq_arbiter_if.master bus
);

    localparam int ACK_W   = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam int BURST_W = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [NREQ-1:0] ONE_REQ = NREQ'(1'b1);

    busrq_arb_state_t   state_q, state_d;
    logic [NREQ-1:0]    grant_q, grant_d;
    logic [OWNER_W-1:0] owner_q, owner_d;
    logic [OWNER_W-1:0] rr_ptr_q, rr_ptr_d;   // where the next search starts
    logic               n_busrq_q, n_busrq_d;
    logic               busy_q, busy_d;
    logic               timeout_q, timeout_d;
    logic [ACK_W-1:0]   ack_cnt_q, ack_cnt_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;

    logic               pick_valid_s;
    logic [OWNER_W-1:0] pick_idx_s;
    logic [OWNER_W-1:0] rr_last_s;
    logic               owner_req_s;
    logic               burst_full_s;
    logic               ack_expired_s;
    logic               burst_end_s;

    // The picker searches from last+1, so hand it the slot before rr_ptr.
    assign rr_last_s = (rr_ptr_q == '0) ? OWNER_W'(NREQ - 1) : rr_ptr_q - OWNER_W'(1'b1);

    busrq_rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .req   (bus.req),
        .last  (rr_last_s),
        .valid (pick_valid_s),
        .idx   (pick_idx_s)
    );

    assign owner_req_s   = |(bus.req & (ONE_REQ << owner_q));
    assign burst_full_s  = (MAX_BURST != 0) && (burst_cnt_q == BURST_W'(MAX_BURST));
    assign ack_expired_s = (ack_cnt_q == ACK_W'(ACK_TIMEOUT - 1));
    assign burst_end_s   = !owner_req_s || burst_full_s || !bus.n_int_next || !bus.en;

    // Next-state and next-output logic for the handshake sequence.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        n_busrq_d   = n_busrq_q;
        // busy mirrors the state one cycle late, so it stays up for the
        // cycle in which the FSM returns to IDLE.
        busy_d      = (state_q != ARB_IDLE);
        timeout_d   = 1'b0;
        ack_cnt_d   = ack_cnt_q;
        burst_cnt_d = burst_cnt_q;

        if (!bus.n_rstcpu) begin
            // CPU held in reset: drop everything, keep the round-robin position.
            state_d     = ARB_IDLE;
            grant_d     = '0;
            n_busrq_d   = 1'b1;
            ack_cnt_d   = '0;
            burst_cnt_d = '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (bus.en && pick_valid_s && bus.n_int_next) begin
                        owner_d   = pick_idx_s;
                        rr_ptr_d  = (pick_idx_s == OWNER_W'(NREQ - 1)) ? '0
                                                                       : pick_idx_s + OWNER_W'(1'b1);
                        n_busrq_d = 1'b0;
                        ack_cnt_d = '0;
                        state_d   = ARB_REQ;
                    end else begin
                        state_d   = ARB_IDLE;
                    end
                end
                ARB_REQ: begin
                    if (!owner_req_s) begin
                        n_busrq_d   = 1'b1;
                        state_d     = ARB_RELEASE;
                    end else if (!bus.n_busak) begin
                        grant_d     = ONE_REQ << owner_q;
                        burst_cnt_d = BURST_W'(1'b1);  // first granted cycle
                        state_d     = ARB_GRANT;
                    end else if (ack_expired_s) begin
                        n_busrq_d   = 1'b1;
                        timeout_d   = 1'b1;
                        ack_cnt_d   = '0;
                        state_d     = ARB_IDLE;
                    end else begin
                        ack_cnt_d   = ack_cnt_q + ACK_W'(1'b1);
                    end
                end
                ARB_GRANT: begin
                    if (burst_end_s) begin
                        grant_d     = '0;
                        state_d     = ARB_TURN;
                    end else begin
                        burst_cnt_d = (burst_cnt_q == '1) ? burst_cnt_q
                                                          : burst_cnt_q + BURST_W'(1'b1);
                    end
                end
                ARB_TURN: begin
                    // Requester has let go of the bus; hand it back to the CPU.
                    n_busrq_d = 1'b1;
                    state_d   = ARB_RELEASE;
                end
                ARB_RELEASE: begin
                    if (bus.n_busak) begin
                        state_d = ARB_IDLE;
                    end else begin
                        state_d = ARB_RELEASE;
                    end
                end
                default: begin
                    state_d   = ARB_IDLE;
                    grant_d   = '0;
                    n_busrq_d = 1'b1;
                end
            endcase
        end
    end

    // State and output registers; async clear returns all outputs to idle.
    always_ff @(posedge clkcpu or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            grant_q     <= '0;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            n_busrq_q   <= 1'b1;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
            ack_cnt_q   <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            n_busrq_q   <= n_busrq_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
            ack_cnt_q   <= ack_cnt_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign bus.n_busrq = n_busrq_q;
    assign bus.grant   = grant_q;
    assign bus.owner   = owner_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_busrq_arbiter.sv
// Bench for busrq_arbiter: a Z80 BUSAK model, a grant scoreboard fed by a
// round-robin reference, and directed timing checks.
module tb_busrq_arbiter;

    logic clkcpu = 1'b0;
    logic rst_n;

    busrq_arbiter_if #(.NREQ(3)) bus ();

    busrq_arbiter #(
        .NREQ        (3),
        .MAX_BURST   (4),
        .ACK_TIMEOUT (8)
    ) dut (
        .clkcpu (clkcpu),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 clkcpu = ~clkcpu;

    typedef struct {
        int owner;
        int len;     // expected grant length in cycles, 0 = not checked
    } exp_t;

    exp_t sb[$];
    int   checks     = 0;
    int   failures   = 0;
    int   model_ptr  = 0;
    bit   cpu_ack_en = 1'b1;
    int   ack_dly    = 2;
    int   cpu_cnt    = 0;
    int   lat;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clkcpu);
            #1;
        end
    endtask

    // Reference round-robin: search from model_ptr, advance past the winner.
    function automatic int arb(input logic [2:0] r);
        int w;
        w = -1;
        for (int i = 0; i < 3; i++) begin
            if (w < 0 && r[(model_ptr + i) % 3]) w = (model_ptr + i) % 3;
        end
        if (w >= 0) model_ptr = (w + 1) % 3;
        return w;
    endfunction

    task automatic expect_grant(input logic [2:0] r, input int len);
        int w;
        w = arb(r);
        sb.push_back('{owner: w, len: len});
    endtask

    task automatic wait_grant(input int budget, output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (bus.grant == 3'b000 && n < budget);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            step(1);
            n++;
        end while (bus.busy != 1'b0 && n < budget);
        chk_eq(tag, 32'(bus.busy), 32'd0);
    endtask

    // Z80 model: asserts BUSAK ack_dly cycles after seeing BUSRQ low.
    initial begin
        bus.n_busak = 1'b1;
        forever begin
            @(posedge clkcpu);
            #1;
            if (bus.n_busrq == 1'b0 && cpu_ack_en) begin
                cpu_cnt++;
                if (cpu_cnt >= ack_dly) bus.n_busak = 1'b0;
            end else begin
                cpu_cnt     = 0;
                bus.n_busak = 1'b1;
            end
        end
    end

    // Grant monitor: pops the scoreboard on each rising grant, checks owner,
    // stability during the burst and the burst length.
    initial begin
        exp_t       cur;
        bit         in_burst;
        int         blen;
        logic [2:0] cur_grant;
        in_burst  = 1'b0;
        blen      = 0;
        cur_grant = 3'b000;
        cur       = '{owner: 0, len: 0};
        forever begin
            @(negedge clkcpu);
            if (!in_burst && bus.grant != 3'b000) begin
                in_burst = 1'b1;
                blen     = 1;
                if (sb.size() == 0) begin
                    chk_eq("unexpected_grant", 32'(bus.grant), 32'd0);
                    cur       = '{owner: 0, len: 0};
                    cur_grant = bus.grant;
                end else begin
                    cur       = sb.pop_front();
                    cur_grant = 3'(3'b001 << cur.owner);
                    chk_eq("grant_onehot", 32'(bus.grant), 32'(cur_grant));
                    chk_eq("grant_owner", 32'(bus.owner), 32'(cur.owner));
                end
            end else if (in_burst && bus.grant != 3'b000) begin
                blen++;
                chk_eq("grant_stable", 32'(bus.grant), 32'(cur_grant));
            end else if (in_burst) begin
                in_burst = 1'b0;
                if (cur.len != 0) chk_eq("burst_len", 32'(blen), 32'(cur.len));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n          = 1'b1;
        bus.n_rstcpu   = 1'b1;
        bus.n_int_next = 1'b1;
        bus.en         = 1'b1;
        bus.req        = 3'b000;
        #2 rst_n = 1'b0;
        step(1);
        chk_eq("rst_n_busrq", 32'(bus.n_busrq), 32'd1);
        chk_eq("rst_grant",   32'(bus.grant),   32'd0);
        chk_eq("rst_owner",   32'(bus.owner),   32'd0);
        chk_eq("rst_busy",    32'(bus.busy),    32'd0);
        chk_eq("rst_timeout", 32'(bus.timeout), 32'd0);
        step(1);
        rst_n = 1'b1;
        step(2);

        // Four back-to-back bursts, all requesters active, limited to 4 cycles.
        for (int k = 0; k < 4; k++) expect_grant(3'b111, 4);
        bus.req = 3'b111;
        begin
            int n;
            n = 0;
            do begin
                step(1);
                n++;
            end while (!(sb.size() == 0 && bus.grant == 3'b000) && n < 150);
            chk_eq("t2_all_bursts", 32'(sb.size()), 32'd0);
        end
        bus.req = 3'b000;
        wait_idle("t2_idle", 20);
        step(2);

        // Single requester, BUSAK two cycles after BUSRQ, then requester drops.
        expect_grant(3'b001, 3);
        bus.req = 3'b001;
        wait_grant(20, lat);
        chk_eq("t1_grant_latency", 32'(lat), 32'd3);
        chk_eq("t1_busy", 32'(bus.busy), 32'd1);
        step(2);
        bus.req = 3'b000;
        step(1);
        chk_eq("t1_grant_drop", 32'(bus.grant), 32'd0);
        chk_eq("t1_turn_busrq", 32'(bus.n_busrq), 32'd0);
        step(1);
        chk_eq("t1_release_busrq", 32'(bus.n_busrq), 32'd1);
        step(2);
        chk_eq("t1_idle_busy", 32'(bus.busy), 32'd0);
        step(2);

        // CPU never acknowledges: timeout 8 cycles after entering REQ.
        cpu_ack_en = 1'b0;
        lat = arb(3'b010);
        bus.req = 3'b010;
        begin
            int n;
            n = 0;
            do begin
                step(1);
                n++;
            end while (bus.timeout == 1'b0 && n < 30);
            chk_eq("t3_timeout_latency", 32'(n), 32'd9);
        end
        chk_eq("t3_busrq", 32'(bus.n_busrq), 32'd1);
        chk_eq("t3_owner", 32'(bus.owner), 32'(lat));
        chk_eq("t3_no_grant", 32'(bus.grant), 32'd0);
        bus.req = 3'b000;
        step(1);
        chk_eq("t3_pulse_width", 32'(bus.timeout), 32'd0);
        chk_eq("t3_idle_busy", 32'(bus.busy), 32'd0);
        cpu_ack_en = 1'b1;
        step(2);

        // Pending INT ends the burst and holds the arbiter in IDLE.
        expect_grant(3'b100, 2);
        bus.req = 3'b100;
        wait_grant(20, lat);
        chk_eq("t4_grant_latency", 32'(lat), 32'd3);
        step(1);
        bus.n_int_next = 1'b0;
        step(1);
        chk_eq("t4_int_grant_drop", 32'(bus.grant), 32'd0);
        for (int i = 0; i < 6; i++) begin
            step(1);
            chk_eq("t4_int_blocks_req", 32'(bus.n_busrq), 32'd1);
        end
        chk_eq("t4_idle_busy", 32'(bus.busy), 32'd0);

        // CPU reset during GRANT aborts straight to IDLE.
        expect_grant(3'b100, 2);
        bus.n_int_next = 1'b1;
        wait_grant(20, lat);
        chk_eq("t5_grant_latency", 32'(lat), 32'd3);
        step(1);
        bus.n_rstcpu = 1'b0;
        step(1);
        chk_eq("t5_abort_grant", 32'(bus.grant), 32'd0);
        chk_eq("t5_abort_busrq", 32'(bus.n_busrq), 32'd1);
        chk_eq("t5_busy_lag", 32'(bus.busy), 32'd1);
        step(1);
        chk_eq("t5_busy_clear", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk_eq("t5_held_busrq", 32'(bus.n_busrq), 32'd1);
        end
        bus.n_rstcpu = 1'b1;
        bus.req      = 3'b000;
        step(2);

        // Async reset mid-burst, then round-robin restarts from requester 0.
        expect_grant(3'b010, 0);
        bus.req = 3'b010;
        wait_grant(20, lat);
        chk_eq("t6_grant_latency", 32'(lat), 32'd3);
        chk_eq("t6_owner_before", 32'(bus.owner), 32'd1);
        step(1);
        #2 rst_n = 1'b0;
        #1;
        chk_eq("t6_async_busrq",   32'(bus.n_busrq), 32'd1);
        chk_eq("t6_async_grant",   32'(bus.grant),   32'd0);
        chk_eq("t6_async_owner",   32'(bus.owner),   32'd0);
        chk_eq("t6_async_busy",    32'(bus.busy),    32'd0);
        chk_eq("t6_async_timeout", 32'(bus.timeout), 32'd0);
        bus.req = 3'b000;
        step(2);
        rst_n     = 1'b1;
        model_ptr = 0;
        step(1);
        chk_eq("t6_owner_after", 32'(bus.owner), 32'd0);
        expect_grant(3'b110, 2);
        bus.req = 3'b110;
        wait_grant(20, lat);
        chk_eq("t6_rr_restart_latency", 32'(lat), 32'd3);
        step(1);
        bus.req = 3'b000;
        wait_idle("t6_idle", 20);
        step(2);

        chk_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
